fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
- REQ-001 RESET_PC, 64'h0000_0000_8000_0000: PC loaded on reset.
- REQ-002 clk  in  1  single clock; all state updates on posedge clk.
- REQ-003 reset  in  1  reset, synchronous, active-high.
- REQ-004 ireq_valid  out  1  instruction-bus request valid.
- REQ-005 ireq_addr  out  64  instruction-bus request address.
- REQ-006 iresp_data_ok  in  1  bus response valid, one-cycle pulse per request.
- REQ-007 iresp_data  in  32  instruction word, valid with iresp_data_ok.
- REQ-008 stall  in  1  decode register cannot accept this cycle.
- REQ-009 redirect_valid  in  1  one-cycle PC redirect (branch/trap).
- REQ-010 redirect_pc  in  64  redirect target.
- REQ-011 out_valid  out  1  output slot holds an instruction for the decode register.
- REQ-012 out_pc  out  64  PC of the slot instruction.
- REQ-013 out_instr  out  32  slot instruction word.
- REQ-014 out_misalign  out  1  slot entry is a misaligned-fetch fault.

Function
- REQ-015 States: IDLE, REQ, DRAIN, FAULT; internal regs pc, req_addr, one-entry output slot.
- REQ-016 consume = out_valid & ~stall; slot cleared on consume unless reloaded that cycle.
- REQ-017 IDLE: if (~out_valid | consume) and no redirect: req_addr <= pc, go REQ; else stay.
- REQ-018 ireq_valid = 1 exactly in REQ and DRAIN; ireq_addr = req_addr, held stable until iresp_data_ok.
- REQ-019 REQ, iresp_data_ok, no redirect: slot <= {1, req_addr, iresp_data, 0}; pc <= pc + 4 (64-bit wrap); go IDLE.
- REQ-020 Slot is guaranteed empty at REQ completion; a request is only launched when the slot is empty or being consumed.
- REQ-021 Redirect priority over consume and response: out_valid <= 0, pc <= redirect_pc, in every state.
- REQ-022 Redirect in REQ without iresp_data_ok: go DRAIN; with iresp_data_ok same cycle: discard data, go IDLE.
- REQ-023 DRAIN: iresp_data_ok discards data, go IDLE; further redirect updates pc only, stays DRAIN.
- REQ-024 Redirect in IDLE or FAULT: go IDLE; no launch that cycle.
- REQ-025 Throughput: at most one instruction per two cycles plus bus latency; no instruction duplicated or dropped absent redirect.
- REQ-026 Outputs are registered; out_* stay constant while out_valid & stall.

Reset
- REQ-027 On reset: pc = RESET_PC, req_addr = 0, state = IDLE, out_valid = 0, out_pc = 0, out_instr = 0, out_misalign = 0, ireq_valid = 0.
- REQ-028 Reset mid-request abandons the outstanding request; a late iresp_data_ok in IDLE is ignored.

Configuration
- REQ-029 FETCH_MISALIGN_CHECK_EN defined: in IDLE with launch condition and pc[1:0] != 0, no request; slot <= {1, pc, 32'h0, 1}; go FAULT; FAULT stays until redirect.
- REQ-030 FETCH_MISALIGN_CHECK_EN undefined: out_misalign tied 0, FAULT unreachable, pc issued as-is.

Verification
- REQ-031 Reset, bus returns data 2 cycles after each request, stall=0 -> out_pc 0x8000_0000, 0x8000_0004, 0x8000_0008 in order, each once.
- REQ-032 stall=1 for 5 cycles with slot full -> out_* constant, ireq_valid=0 throughout, next fetch starts the cycle stall drops.
- REQ-033 Redirect to 0x8000_0100 while REQ pending, data_ok 3 cycles later -> ireq_addr held old value, data discarded, next request addr 0x8000_0100.
- REQ-034 Redirect and data_ok same cycle -> no out_valid for old data, next request 0x8000_0100.
- REQ-035 (FETCH_MISALIGN_CHECK_EN) redirect to 0x8000_0102 -> out_valid=1, out_misalign=1, out_pc 0x8000_0102, no ireq_valid until redirect to 0x8000_0200.
- REQ-036 reset asserted during REQ -> next cycle all outputs at reset values, first request RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding bus request feeding a one-entry output slot.
// Optional misaligned-PC fault detection is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_ctrl (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misalign
);

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } fetchState_t;

  fetchState_t state, nextState;

  logic [63:0] pc;
  logic [63:0] reqAddr;
  logic        outValid;
  logic [63:0] outPc;
  logic [31:0] outInstr;
  logic        consume;
  logic        slotFree;
  logic        launch;
  logic        loadData;
  logic        loadFault;

  assign consume  = outValid & ~stall;
  assign slotFree = ~outValid | consume;

  // Next-state and per-cycle load decisions; a redirect always wins over launch and slot load.
  always_comb begin
    nextState = state;
    launch    = 1'b0;
    loadData  = 1'b0;
    loadFault = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect_valid && slotFree) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (pc[1:0] != 2'b00) begin
            loadFault = 1'b1;
            nextState = FAULT;
          end else begin
            launch    = 1'b1;
            nextState = REQ;
          end
`else
          launch    = 1'b1;
          nextState = REQ;
`endif
        end
      end
      REQ: begin
        if (iresp_data_ok) begin
          loadData  = ~redirect_valid;
          nextState = IDLE;
        end else if (redirect_valid) begin
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        // The stale response must be swallowed before a new request may go out.
        if (iresp_data_ok) begin
          nextState = IDLE;
        end
      end
      FAULT: begin
        if (redirect_valid) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State register, PC, request address and output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      reqAddr  <= 64'd0;
      outValid <= 1'b0;
      outPc    <= 64'd0;
      outInstr <= 32'd0;
    end else begin
      state <= nextState;
      if (launch) begin
        reqAddr <= pc;
      end
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (loadData) begin
        pc <= pc + 64'd4;
      end
      if (redirect_valid) begin
        outValid <= 1'b0;
      end else if (loadData) begin
        outValid <= 1'b1;
        outPc    <= reqAddr;
        outInstr <= iresp_data;
      end else if (loadFault) begin
        outValid <= 1'b1;
        outPc    <= pc;
        outInstr <= 32'd0;
      end else if (consume) begin
        outValid <= 1'b0;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic outMisalign;

  always_ff @(posedge clk) begin
    if (reset) begin
      outMisalign <= 1'b0;
    end else if (!redirect_valid && loadData) begin
      outMisalign <= 1'b0;
    end else if (!redirect_valid && loadFault) begin
      outMisalign <= 1'b1;
    end
  end

  assign out_misalign = outMisalign;
`else
  assign out_misalign = 1'b0;
`endif

  assign ireq_valid = (state == REQ) || (state == DRAIN);
  assign ireq_addr  = reqAddr;
  assign out_valid  = outValid;
  assign out_pc     = outPc;
  assign out_instr  = outInstr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: in-order fetch, stall hold, redirects, reset mid-request
// and, when FETCH_MISALIGN_CHECK_EN is defined, the misaligned-fetch fault path.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misalign;

  int compared   = 0;
  int mismatched = 0;

  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_misalign  (out_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic stl, input logic redir, input logic [63:0] rpc);
    reset          = rst;
    stall          = stl;
    redirect_valid = redir;
    redirect_pc    = rpc;
  endtask

  // Holds the response back for lat cycles while checking the request stays put, then pulses data_ok.
  task automatic respond(input logic [31:0] d, input int lat, input logic [63:0] addr);
    for (int k = 0; k < lat; k++) begin
      checkOutput("reqValid", {63'd0, ireq_valid}, 64'd1);
      checkOutput("reqAddrHeld", ireq_addr, addr);
      if (k == lat - 1) begin
        iresp_data_ok = 1'b1;
        iresp_data    = d;
      end
      tick();
    end
    iresp_data_ok = 1'b0;
  endtask

  task automatic checkReset();
    checkOutput("rstOutValid", {63'd0, out_valid}, 64'd0);
    checkOutput("rstOutPc", out_pc, 64'd0);
    checkOutput("rstOutInstr", {32'd0, out_instr}, 64'd0);
    checkOutput("rstMisalign", {63'd0, out_misalign}, 64'd0);
    checkOutput("rstReqValid", {63'd0, ireq_valid}, 64'd0);
    checkOutput("rstReqAddr", ireq_addr, 64'd0);
  endtask

  logic [31:0] instrs [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_8113, 32'h0031_0193};

  initial begin
    iresp_data_ok = 1'b0;
    iresp_data    = 32'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
    tick();
    tick();
    checkReset();

    // Three sequential fetches, data two cycles after each request, no stall.
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      respond(instrs[i], 2, 64'h8000_0000 + 64'(4 * i));
      checkOutput("seqValid", {63'd0, out_valid}, 64'd1);
      checkOutput("seqPc", out_pc, 64'h8000_0000 + 64'(4 * i));
      checkOutput("seqInstr", {32'd0, out_instr}, {32'd0, instrs[i]});
      checkOutput("seqMisalign", {63'd0, out_misalign}, 64'd0);
      tick();
      checkOutput("seqConsumedOnce", {63'd0, out_valid}, 64'd0);
    end

    // Stall five cycles with the slot full.
    applyStimulus(1'b0, 1'b1, 1'b0, 64'd0);
    respond(instrs[3], 2, 64'h8000_000C);
    for (int k = 0; k < 5; k++) begin
      checkOutput("stallValid", {63'd0, out_valid}, 64'd1);
      checkOutput("stallPc", out_pc, 64'h8000_000C);
      checkOutput("stallInstr", {32'd0, out_instr}, {32'd0, instrs[3]});
      checkOutput("stallNoReq", {63'd0, ireq_valid}, 64'd0);
      if (k < 4) tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    tick();
    checkOutput("unstallReq", {63'd0, ireq_valid}, 64'd1);
    checkOutput("unstallAddr", ireq_addr, 64'h8000_0010);
    checkOutput("unstallEmpty", {63'd0, out_valid}, 64'd0);

    // Redirect while a request is pending; data arrives three cycles later and is dropped.
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_0100);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    respond(32'hDEAD_BEEF, 2, 64'h8000_0010);
    checkOutput("drainDropped", {63'd0, out_valid}, 64'd0);
    checkOutput("drainIdle", {63'd0, ireq_valid}, 64'd0);
    tick();
    checkOutput("drainNextAddr", ireq_addr, 64'h8000_0100);
    checkOutput("drainNextReq", {63'd0, ireq_valid}, 64'd1);

    // Complete 0x100, then redirect coincident with the response for 0x104.
    respond(32'h1111_1111, 1, 64'h8000_0100);
    checkOutput("tgtPc", out_pc, 64'h8000_0100);
    checkOutput("tgtInstr", {32'd0, out_instr}, 64'h1111_1111);
    tick();
    checkOutput("nextAddr104", ireq_addr, 64'h8000_0104);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_0100);
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hBAD0_BAD0;
    tick();
    iresp_data_ok = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    checkOutput("sameCycDropped", {63'd0, out_valid}, 64'd0);
    checkOutput("sameCycIdle", {63'd0, ireq_valid}, 64'd0);
    tick();
    checkOutput("sameCycNextAddr", ireq_addr, 64'h8000_0100);

    // Redirect in IDLE with a stalled full slot clears it and suppresses launch for a cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 64'd0);
    respond(32'h2222_2222, 1, 64'h8000_0100);
    checkOutput("idleFull", {63'd0, out_valid}, 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_0040);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    checkOutput("idleRedirClr", {63'd0, out_valid}, 64'd0);
    checkOutput("idleRedirNoReq", {63'd0, ireq_valid}, 64'd0);
    tick();
    checkOutput("idleRedirAddr", ireq_addr, 64'h8000_0040);

    // Reset during a request; a late response right after is ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
    tick();
    checkReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h3333_3333;
    tick();
    iresp_data_ok = 1'b0;
    checkOutput("lateRespIgnored", {63'd0, out_valid}, 64'd0);
    checkOutput("postRstAddr", ireq_addr, 64'h8000_0000);
    checkOutput("postRstReq", {63'd0, ireq_valid}, 64'd1);

    // Misaligned target: fault entry with checking enabled, plain request otherwise.
    respond(32'h4444_4444, 1, 64'h8000_0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_0102);
    iresp_data_ok = 1'b1;
    tick();
    iresp_data_ok = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput("faultValid", {63'd0, out_valid}, 64'd1);
    checkOutput("faultMisalign", {63'd0, out_misalign}, 64'd1);
    checkOutput("faultPc", out_pc, 64'h8000_0102);
    for (int k = 0; k < 3; k++) begin
      checkOutput("faultNoReq", {63'd0, ireq_valid}, 64'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_0200);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    checkOutput("faultExitNoReq", {63'd0, ireq_valid}, 64'd0);
    tick();
    checkOutput("faultExitAddr", ireq_addr, 64'h8000_0200);
    checkOutput("faultExitReq", {63'd0, ireq_valid}, 64'd1);
`else
    checkOutput("misReqValid", {63'd0, ireq_valid}, 64'd1);
    checkOutput("misReqAddr", ireq_addr, 64'h8000_0102);
    respond(32'h5555_5555, 1, 64'h8000_0102);
    checkOutput("misOutPc", out_pc, 64'h8000_0102);
    checkOutput("misNoFlag", {63'd0, out_misalign}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
